// File: rtl/blake_finalize.sv
// BLAKE finalization: two-stage feed-forward/threshold pipeline feeding a golden-nonce FIFO.
// Define BLAKE_FINALIZE_FULLHASH_EN to store and present the full 256-bit hash per FIFO entry.
module blake_finalize #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [511:0] v_in,
    input  logic [255:0] h_in,
    input  logic [127:0] s_in,
    input  logic [31:0]  nonce_in,
    input  logic [31:0]  target_in,
    output logic         gn_valid,
    input  logic         gn_ready,
    output logic [31:0]  gn_nonce,
    output logic [255:0] gn_hash,
    output logic         overflow,
    output logic [31:0]  hash_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [255:0]  hw_d;
    logic          s1_valid;
    logic [255:0]  s1_hash;
    logic [31:0]   s1_nonce;
    logic [31:0]   s1_target;
    logic [31:0]   s1_hw7_rev;
    logic          s2_valid;
    logic          s2_match;
    logic [255:0]  s2_hash;
    logic [31:0]   s2_nonce;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          wr_en;
    logic [31:0]   hash_cnt;
    logic [31:0]   nonce_mem [FIFO_DEPTH];

    always_comb begin
        hw_d = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            hw_d[32*i +: 32] = h_in[32*i +: 32] ^ s_in[32*(i%4) +: 32]
                             ^ v_in[32*i +: 32] ^ v_in[32*(i+8) +: 32];
        end
    end

    // hw7 is compared as a big-endian word, hence the byte reversal
    assign s1_hw7_rev = {s1_hash[231:224], s1_hash[239:232], s1_hash[247:240], s1_hash[255:248]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_hash   <= '0;
            s1_nonce  <= '0;
            s1_target <= '0;
            s2_valid  <= 1'b0;
            s2_match  <= 1'b0;
            s2_hash   <= '0;
            s2_nonce  <= '0;
            hash_cnt  <= '0;
        end else begin
            s1_valid  <= in_valid;
            s1_hash   <= hw_d;
            s1_nonce  <= nonce_in;
            s1_target <= target_in;
            s2_valid  <= s1_valid;
            s2_match  <= (s1_hw7_rev <= s1_target);
            s2_hash   <= s1_hash;
            s2_nonce  <= s1_nonce;
            if (in_valid) hash_cnt <= hash_cnt + 32'd1;
        end
    end

    assign gn_valid  = (wr_ptr != rd_ptr);
    assign fifo_full = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    assign push      = s2_valid & s2_match;
    assign pop       = gn_valid & gn_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push
    assign wr_en     = push & (~fifo_full | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
            if (push && fifo_full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) nonce_mem[wr_ptr[AW-1:0]] <= s2_nonce;
    end

    assign gn_nonce   = gn_valid ? nonce_mem[rd_ptr[AW-1:0]] : '0;
    assign hash_count = hash_cnt;

`ifdef BLAKE_FINALIZE_FULLHASH_EN
    logic [255:0] hash_mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) hash_mem[wr_ptr[AW-1:0]] <= s2_hash;
    end

    assign gn_hash = gn_valid ? hash_mem[rd_ptr[AW-1:0]] : '0;
`else
    logic unused_hash;

    assign unused_hash = ^s2_hash;
    assign gn_hash     = '0;
`endif

endmodule

// File: doc/blake_finalize.md
BLAKE_FINALIZE -- requirements
Module: blake_finalize

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the golden-nonce FIFO depth in entries; only powers of two from 2 to 16 are legal.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 in_valid  in  1  SHALL qualify v_in, h_in, s_in, nonce_in and target_in for one cycle.
REQ-005 v_in  in  512  final-round state v0..v15, with v0 at bits [31:0].
REQ-006 h_in  in  256  chaining value h0..h7, with h0 at bits [31:0].
REQ-007 s_in  in  128  salt s0..s3, with s0 at bits [31:0].
REQ-008 nonce_in  in  32  nonce tag travelling with the data.
REQ-009 target_in  in  32  compare threshold.
REQ-010 gn_valid  out  1  FIFO non-empty.
REQ-011 gn_ready  in  1  pop request.
REQ-012 gn_nonce  out  32  FIFO head nonce.
REQ-013 gn_hash  out  256  FIFO head hash.
REQ-014 overflow  out  1  sticky flag, set when a match is dropped.
REQ-015 hash_count  out  32  count of accepted in_valid beats.

Function
REQ-016 Stage 1 SHALL register hw_i = h_i ^ s_(i mod 4) ^ v_i ^ v_(i+8) for i = 0..7, together with nonce, target and a valid bit.
REQ-017 Stage 2 SHALL register match = (byte-reversed hw7, taken as unsigned) <= target, plus the stage-1 hash, nonce and valid.
REQ-018 The block SHALL be fully pipelined, accept one beat per cycle and provide no back-pressure on the input side.
REQ-019 A beat that has stage-2 valid and match high SHALL be written into the FIFO; the write occurs on the second rising edge after the input beat is sampled.
REQ-020 gn_valid SHALL rise in the cycle after the FIFO write edge, i.e. 3 cycles after input.
REQ-021 A pop SHALL occur on each edge where gn_valid and gn_ready are both high.
REQ-022 The FIFO head SHALL remain stable while gn_valid is high and gn_ready is low.
REQ-023 FIFO pointers SHALL use log2(FIFO_DEPTH)+1 bits: empty when the pointers are equal; full when the pointers differ only in the MSB; both pointers wrap naturally.
REQ-024 A simultaneous push and pop while full SHALL be accepted with no drop and no flag.
REQ-025 A simultaneous push and pop while empty SHALL write only; the pop is ignored because gn_valid is low.
REQ-026 A push while full without a pop SHALL drop the new entry, leave the FIFO contents unchanged and set overflow, which stays high until reset.
REQ-027 hash_count SHALL increment on each sampled in_valid and wrap from 0xFFFFFFFF to 0.
REQ-028 When gn_valid is low, gn_nonce and gn_hash SHALL read 0.

Reset
REQ-029 Asserting rst_n low SHALL immediately clear all pipeline valid bits, the FIFO pointers, overflow and hash_count.
REQ-030 While rst_n is low, gn_valid SHALL be 0, gn_nonce 0, gn_hash 0, overflow 0 and hash_count 0.
REQ-031 Any beats in flight during reset SHALL be discarded, and no FIFO write SHALL occur on or after the reset edge.
REQ-032 The first beat sampled after rst_n deasserts SHALL see normal 2-cycle latency.

Configuration
REQ-033 With macro BLAKE_FINALIZE_FULLHASH_EN defined, FIFO entries SHALL store the nonce plus the full 256-bit hash, and gn_hash SHALL present the head hash.
REQ-034 Without BLAKE_FINALIZE_FULLHASH_EN, FIFO entries SHALL store the nonce only, gn_hash SHALL be tied to 0, and all other behaviour and latency SHALL be unchanged.

Verification
REQ-035 Feed-forward check: v_in all 0, s_in 0, h_in words = i+1, target 0xFFFFFFFF, nonce 0x11 -> gn_valid high 3 cycles later, gn_nonce 0x11, gn_hash words 1..8 (with FULLHASH_EN).
REQ-036 Threshold boundary: hw7 = 0x00000100 (byte-reversed 0x00010000) with target 0x00010000 -> pushed; the same beat with target 0x0000FFFF -> not pushed, yet hash_count still increments.
REQ-037 Overflow: FIFO_DEPTH 4, gn_ready 0, six consecutive matching beats (nonces 1..6) -> FIFO holds 1..4, overflow high from the 5th write edge, later pops return 1,2,3,4.
REQ-038 Full push+pop: FIFO full and gn_ready 1 while a matching beat with nonce 9 arrives -> no overflow, and the final pop order ends ...,9.
REQ-039 Mid-flight reset: two matching beats in the pipe, rst_n pulsed low for 1 cycle -> gn_valid stays 0, and hash_count and overflow read 0.
REQ-040 Counter wrap: hash_count preloaded to 0xFFFFFFFE via 2^32-2 beats, or forced in simulation, then 3 beats -> hash_count reads 0x00000001.
